// File: rtl/riscv_fetch.sv
// Instruction fetch: in-order icache reads, buffered {pc, instr} handed to decode under valid/accept.
// Credit (in-flight + buffered <= FIFO_DEPTH) keeps responses unthrottled; min request-to-valid 2 cycles.
module riscv_fetch #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_branch_i,
  input  logic [31:0] fetch_branch_pc_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o,
  input  logic        fetch_accept_i,
  output logic        icache_rd_o,
  output logic [31:0] icache_pc_o,
  input  logic        icache_accept_i,
  input  logic        icache_valid_i,
  input  logic [31:0] icache_inst_i
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0]   DEPTH_U = FIFO_DEPTH[CW:0];
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [0:0]    ST_IDLE = 1'b0;
  localparam logic [0:0]    ST_RUN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] pending_q, pending_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] tag_wr_q, tag_rd_q, buf_wr_q, buf_rd_q;
  logic [31:0]   tag_mem_q   [FIFO_DEPTH];
  logic [31:0]   buf_pc_q    [FIFO_DEPTH];
  logic [31:0]   buf_instr_q [FIFO_DEPTH];

  logic [CW:0] used;
  logic        req_fire, rsp_fire, rsp_drop, buf_push, buf_pop;

  assign fetch_valid_o = (count_q != '0);
  assign fetch_instr_o = fetch_valid_o ? buf_instr_q[buf_rd_q] : 32'h0;
  assign fetch_pc_o    = fetch_valid_o ? buf_pc_q[buf_rd_q]    : 32'h0;
  assign icache_pc_o   = pc_q;

  always_comb begin
    used        = {1'b0, pending_q} + {1'b0, count_q};
    icache_rd_o = (state_q == ST_RUN) && (used < DEPTH_U) && !fetch_branch_i;
    req_fire    = icache_rd_o && icache_accept_i;
    // A response with nothing outstanding is a protocol error and is ignored.
    rsp_fire    = icache_valid_i && (pending_q != '0);
    rsp_drop    = rsp_fire && (discard_q != '0);
    buf_push    = rsp_fire && !rsp_drop && !fetch_branch_i;
    buf_pop     = fetch_valid_o && fetch_accept_i && !fetch_branch_i;

    pending_d = pending_q + {{(CW-1){1'b0}}, req_fire} - {{(CW-1){1'b0}}, rsp_fire};
    // On redirect every request still outstanding after this edge is stale.
    discard_d = fetch_branch_i ? pending_d
                               : discard_q - {{(CW-1){1'b0}}, rsp_drop};
    count_d   = fetch_branch_i ? '0
                               : count_q + {{(CW-1){1'b0}}, buf_push} - {{(CW-1){1'b0}}, buf_pop};

    pc_d    = pc_q;
    state_d = state_q;
    if (fetch_branch_i) begin
      pc_d    = {fetch_branch_pc_i[31:2], 2'b00};
      state_d = ST_RUN;
    end else if (req_fire) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      pc_q      <= 32'h0;
      pending_q <= '0;
      discard_q <= '0;
      count_q   <= '0;
      tag_wr_q  <= '0;
      tag_rd_q  <= '0;
      buf_wr_q  <= '0;
      buf_rd_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      discard_q <= discard_d;
      count_q   <= count_d;
      if (req_fire) tag_wr_q <= tag_wr_q + PTR_ONE;
      if (rsp_fire) tag_rd_q <= tag_rd_q + PTR_ONE;
      if (fetch_branch_i) begin
        buf_wr_q <= '0;
        buf_rd_q <= '0;
      end else begin
        if (buf_push) buf_wr_q <= buf_wr_q + PTR_ONE;
        if (buf_pop)  buf_rd_q <= buf_rd_q + PTR_ONE;
      end
    end
  end

  // Storage needs no reset: occupancy and pending counters gate every read.
  always_ff @(posedge clk_i) begin
    if (req_fire) tag_mem_q[tag_wr_q] <= pc_q;
    if (buf_push) begin
      buf_pc_q[buf_wr_q]    <= tag_mem_q[tag_rd_q];
      buf_instr_q[buf_wr_q] <= icache_inst_i;
    end
  end

endmodule

// File: tb/tb_riscv_fetch.sv
// Bench for riscv_fetch: bench-side icache with random latency, and an in-order stream model of the
// expected request and output PCs that restarts at each redirect target.
module tb_riscv_fetch;
  localparam int DEPTH = 2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        fetch_branch_i = 1'b0;
  logic [31:0] fetch_branch_pc_i = 32'h0;
  logic        fetch_valid_o;
  logic [31:0] fetch_instr_o;
  logic [31:0] fetch_pc_o;
  logic        fetch_accept_i = 1'b0;
  logic        icache_rd_o;
  logic [31:0] icache_pc_o;
  logic        icache_accept_i = 1'b0;
  logic        icache_valid_i = 1'b0;
  logic [31:0] icache_inst_i = 32'h0;

  always #5 clk_i = ~clk_i;

  riscv_fetch #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .fetch_branch_i(fetch_branch_i), .fetch_branch_pc_i(fetch_branch_pc_i),
    .fetch_valid_o(fetch_valid_o), .fetch_instr_o(fetch_instr_o), .fetch_pc_o(fetch_pc_o),
    .fetch_accept_i(fetch_accept_i),
    .icache_rd_o(icache_rd_o), .icache_pc_o(icache_pc_o), .icache_accept_i(icache_accept_i),
    .icache_valid_i(icache_valid_i), .icache_inst_i(icache_inst_i)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [31:0] cq[$];
  int          cq_rdy[$];
  int acc_pct = 100, rsp_pct = 100, dacc_pct = 100, lat_extra = 0;
  bit hold_rsp = 0, force_rsp = 0, force_acc = 0;
  bit br = 0;
  logic [31:0] br_pc = 32'h0;
  logic [31:0] exp_req = 32'h0, exp_out = 32'h0;
  int nreq = 0, nout = 0;
  logic [31:0] outs[$];
  logic        s_rd, s_valid, s_rvld;
  logic [31:0] s_ipc, s_fpc, s_instr;

  function automatic logic [31:0] mem(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'hC0DE_1234;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, sample #1 later, advance the model, then take the rising edge.
  task automatic tick();
    logic rv;
    @(negedge clk_i);
    rv = 1'b0;
    if (cq.size() > 0 && !hold_rsp && cq_rdy[0] <= cyc)
      rv = force_rsp || (int'($urandom_range(0, 99)) < rsp_pct);
    icache_valid_i = rv;
    icache_inst_i  = 32'h0;
    if (rv) icache_inst_i = mem(cq[0]);
    icache_accept_i   = force_acc || (int'($urandom_range(0, 99)) < acc_pct);
    fetch_accept_i    = (int'($urandom_range(0, 99)) < dacc_pct);
    fetch_branch_i    = br;
    fetch_branch_pc_i = br_pc;
    #1;
    s_rd = icache_rd_o; s_ipc = icache_pc_o; s_valid = fetch_valid_o;
    s_fpc = fetch_pc_o; s_instr = fetch_instr_o; s_rvld = rv;
    if (br) check("no_req_in_branch", 32'(s_rd), 32'd0);
    if (s_rd && icache_accept_i) begin
      check("req_pc", s_ipc, exp_req);
      cq.push_back(s_ipc);
      cq_rdy.push_back(cyc + 1 + int'($urandom_range(0, lat_extra)));
      exp_req += 32'd4;
      nreq++;
    end
    if (rv) begin
      void'(cq.pop_front());
      void'(cq_rdy.pop_front());
    end
    if (!br && s_valid && fetch_accept_i) begin
      check("out_pc", s_fpc, exp_out);
      check("out_instr", s_instr, mem(exp_out));
      outs.push_back(s_fpc);
      exp_out += 32'd4;
      nout++;
    end
    if (br) begin
      exp_req = br_pc & ~32'h3;
      exp_out = br_pc & ~32'h3;
    end
    @(posedge clk_i);
    cyc++;
  endtask

  task automatic branch_to(input logic [31:0] pc);
    br = 1'b1; br_pc = pc;
    tick();
    br = 1'b0;
  endtask

  task automatic run_until_out(input int target, input int budget, input string tag);
    int n = 0;
    while (nout < target && n < budget) begin tick(); n++; end
    check(tag, 32'(nout >= target), 32'd1);
  endtask

  task automatic quiesce();
    int n = 0;
    acc_pct = 0; rsp_pct = 100; hold_rsp = 0;
    while (cq.size() > 0 && n < 30) begin tick(); n++; end
    check("quiesce", 32'(cq.size()), 32'd0);
    acc_pct = 100;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rd"},    32'(icache_rd_o),   32'd0);
    check({tag, "_ipc"},   icache_pc_o,        32'd0);
    check({tag, "_valid"}, 32'(fetch_valid_o), 32'd0);
    check({tag, "_pc"},    fetch_pc_o,         32'd0);
    check({tag, "_instr"}, fetch_instr_o,      32'd0);
  endtask

  initial begin
    int k, n0, r0;
    // 1: reset state and idle without a branch
    #1 check_zero_outputs("rst");
    @(posedge clk_i); cyc++;
    @(negedge clk_i); rst_i = 1'b1;
    acc_pct = 50;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_rd", 32'(s_rd), 32'd0);
      check("idle_valid", 32'(s_valid), 32'd0);
    end

    // 2: vector jump, 1-cycle cache, everything accepted
    acc_pct = 100; rsp_pct = 100; dacc_pct = 100; lat_extra = 0;
    k = outs.size(); n0 = nout;
    branch_to(32'h8000_0000);
    tick(); tick(); tick();
    check("min_latency_outs", 32'(nout - n0), 32'd1);
    run_until_out(n0 + 8, 60, "t2_progress");
    if (outs.size() > k) check("t2_first_pc", outs[k], 32'h8000_0000);

    // 3: decode stalled -> credit limit, then drain
    dacc_pct = 0;
    branch_to(32'h0000_1000);
    r0 = nreq;
    for (int i = 0; i < 12; i++) tick();
    check("t3_req_count", 32'(nreq - r0), 32'(DEPTH));
    check("t3_rd_stalled", 32'(s_rd), 32'd0);
    check("t3_valid_held", 32'(s_valid), 32'd1);
    dacc_pct = 100;
    run_until_out(nout + 6, 40, "t3_drain");
    check("t3_resumed", 32'(nreq - r0 > DEPTH), 32'd1);

    // 4: two requests in flight, redirect drops both responses
    quiesce();
    hold_rsp = 1;
    branch_to(32'h0000_0100);
    tick(); tick(); tick();
    check("t4_inflight", 32'(cq.size()), 32'd2);
    check("t4_credit_full", 32'(s_rd), 32'd0);
    branch_to(32'h0000_0200);
    hold_rsp = 0;
    k = outs.size();
    run_until_out(nout + 1, 30, "t4_progress");
    if (outs.size() > k) check("t4_first_pc", outs[k], 32'h0000_0200);

    // 5: branch, response and cache accept on the same edge
    quiesce();
    hold_rsp = 1;
    branch_to(32'h0000_0300);
    tick(); tick(); tick();
    check("t5_inflight", 32'(cq.size()), 32'd2);
    hold_rsp = 0; force_rsp = 1; force_acc = 1;
    branch_to(32'h0000_0400);
    check("t5_rsp_in_branch", 32'(s_rvld), 32'd1);
    force_rsp = 0; force_acc = 0;
    k = outs.size();
    run_until_out(nout + 3, 40, "t5_progress");
    if (outs.size() > k) check("t5_first_pc", outs[k], 32'h0000_0400);

    // 6: unaligned target and address wrap, then reset mid-burst
    k = outs.size();
    branch_to(32'hFFFF_FFFB);
    run_until_out(nout + 3, 40, "t6_progress");
    if (outs.size() > k + 2) begin
      check("t6_pc0", outs[k],     32'hFFFF_FFF8);
      check("t6_pc1", outs[k + 1], 32'hFFFF_FFFC);
      check("t6_pc2", outs[k + 2], 32'h0000_0000);
    end
    dacc_pct = 0;
    tick(); tick();
    @(negedge clk_i); rst_i = 1'b0;
    #1 check_zero_outputs("midrst");
    @(posedge clk_i); cyc++;
    cq.delete(); cq_rdy.delete();
    cq.push_back(32'h0000_0040); cq_rdy.push_back(0);
    @(negedge clk_i); rst_i = 1'b1;
    dacc_pct = 100;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_valid", 32'(s_valid), 32'd0);
      check("post_rst_rd", 32'(s_rd), 32'd0);
    end

    // Randomised traffic with random redirects
    cq.delete(); cq_rdy.delete();
    branch_to(32'h0000_2000);
    acc_pct = 70; rsp_pct = 60; dacc_pct = 60; lat_extra = 3;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 4) branch_to($urandom);
      else tick();
    end
    acc_pct = 100; rsp_pct = 100; dacc_pct = 100; lat_extra = 0;
    run_until_out(nout + 5, 60, "rand_progress");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
